// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related
// shared-peripheral arbiters.
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam logic [7:0] NEWLINE = 8'h0A;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value t.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request strictly after the
// pointer, wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic          hi_found, lo_found;
    logic [IW-1:0] hi_idx, lo_idx;

    // Scan downwards so the lowest index in each half wins; the half above
    // the pointer has priority over the wrapped half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i > int'(ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(i);
                end
            end
        end
        found_o = hi_found | lo_found;
        idx_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte interface between NUM_REQ
// requesters, with optional line locking and an owner idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LINE_LOCK    = 1,
    parameter int LOCK_TIMEOUT = 256,
    localparam int GW = idx_width(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [GW-1:0]          grant_id_o,
    output logic                   locked_o,
    output logic                   busy_o
);

    localparam int             CW      = cnt_width(LOCK_TIMEOUT);
    localparam bit             TO_EN   = (LOCK_TIMEOUT > 0);
    localparam logic [CW-1:0]  TO_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    arb_state_e     state_q;
    logic [GW-1:0]  grant_q;
    logic [GW-1:0]  ptr_q;
    logic [7:0]     tx_data_q;
    logic           tx_valid_q;
    logic [CW-1:0]  idle_cnt_q;

    logic [7:0]     lane [NUM_REQ];
    logic           owned, slot_free, own_valid, hs;
    logic           nl_rel, to_rel;
    logic [7:0]     own_byte;
    logic           pick_found;
    logic [GW-1:0]  pick_idx;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign lane[k] = req_data_i[8*k +: 8];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owned     = (state_q == ARB_OWNED);
    assign slot_free = !tx_valid_q || tx_ready_i;
    assign own_valid = req_valid_i[grant_q];
    assign own_byte  = lane[grant_q];
    assign hs        = owned && slot_free && own_valid;

    // A newline (or any byte without line locking) ends the owner's turn;
    // the timeout only fires while the owner itself has nothing to offer.
    assign nl_rel = hs && ((LINE_LOCK == 0) || (own_byte == NEWLINE));
    assign to_rel = TO_EN && owned && !own_valid && (idle_cnt_q == TO_LAST);

    always_comb begin
        req_ready_o = '0;
        if (owned && slot_free) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= GW'(NUM_REQ - 1);
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            if (hs) begin
                tx_data_q  <= own_byte;
                tx_valid_q <= 1'b1;
            end else if (tx_ready_i) begin
                tx_valid_q <= 1'b0;
            end

            case (state_q)
                ARB_IDLE: begin
                    idle_cnt_q <= '0;
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if (nl_rel || to_rel) begin
                        state_q    <= ARB_IDLE;
                        ptr_q      <= grant_q;
                        idle_cnt_q <= '0;
                    end else if (hs) begin
                        idle_cnt_q <= '0;
                    end else if (!own_valid) begin
                        idle_cnt_q <= idle_cnt_q + CW'(1);
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign grant_id_o = grant_q;
    assign locked_o   = owned;
    assign busy_o     = owned || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter using three instances
// (default, no line lock, short timeout) that share one stimulus set.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rstn;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic        tx_ready;

    logic [1:0] a_req_ready, b_req_ready, c_req_ready;
    logic [7:0] a_tx_data, b_tx_data, c_tx_data;
    logic       a_tx_valid, b_tx_valid, c_tx_valid;
    logic       a_grant, b_grant, c_grant;
    logic       a_locked, b_locked, c_locked;
    logic       a_busy, b_busy, c_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] src0[$], src1[$], exp0[$], exp1[$], cap[$];

    uart_tx_arbiter #(.NUM_REQ(2), .LINE_LOCK(1), .LOCK_TIMEOUT(256)) u_a (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_ready_o(a_req_ready), .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid),
        .tx_ready_i(tx_ready), .grant_id_o(a_grant), .locked_o(a_locked), .busy_o(a_busy));

    uart_tx_arbiter #(.NUM_REQ(2), .LINE_LOCK(0), .LOCK_TIMEOUT(0)) u_b (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_ready_o(b_req_ready), .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid),
        .tx_ready_i(tx_ready), .grant_id_o(b_grant), .locked_o(b_locked), .busy_o(b_busy));

    uart_tx_arbiter #(.NUM_REQ(2), .LINE_LOCK(1), .LOCK_TIMEOUT(8)) u_c (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_ready_o(c_req_ready), .tx_data_o(c_tx_data), .tx_valid_o(c_tx_valid),
        .tx_ready_i(tx_ready), .grant_id_o(c_grant), .locked_o(c_locked), .busy_o(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0;
        tx_ready  = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Drives src0/src1 as valid/ready sources and records every byte the
    // UART side of instance A takes into cap.
    task automatic run_traffic(input bit rnd, input int budget);
        bit pend0, pend1, hs0, hs1, txhs, done;
        int gap0, gap1;
        logic [7:0] txb;
        pend0 = 0; pend1 = 0; gap0 = 0; gap1 = 0; done = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            if (src0.size() > 0 && (pend0 || !rnd || gap0 >= 3 || $urandom_range(3) != 0)) begin
                req_valid[0] = 1'b1; req_data[7:0] = src0[0]; gap0 = 0;
            end else begin
                req_valid[0] = 1'b0; gap0++;
            end
            if (src1.size() > 0 && (pend1 || !rnd || gap1 >= 3 || $urandom_range(3) != 0)) begin
                req_valid[1] = 1'b1; req_data[15:8] = src1[0]; gap1 = 0;
            end else begin
                req_valid[1] = 1'b0; gap1++;
            end
            tx_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
            #4;
            hs0  = req_valid[0] && a_req_ready[0];
            hs1  = req_valid[1] && a_req_ready[1];
            txhs = a_tx_valid && tx_ready;
            txb  = a_tx_data;
            tick();
            if (hs0) void'(src0.pop_front());
            if (hs1) void'(src1.pop_front());
            pend0 = req_valid[0] && !hs0;
            pend1 = req_valid[1] && !hs1;
            if (txhs) cap.push_back(txb);
            done = (src0.size() == 0) && (src1.size() == 0) && !a_tx_valid;
        end
        req_valid = 2'b00;
        tx_ready  = 1'b1;
        check("traffic_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] e;
        int cur, r, nl, len, total;

        // Reset state
        rstn = 1'b0; req_valid = 2'b00; req_data = 16'h0; tx_ready = 1'b1;
        tick();
        check("rst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, a_tx_data},  32'd0);
        check("rst_req_ready", {30'd0, a_req_ready}, 32'd0);
        check("rst_grant",    {31'd0, a_grant},    32'd0);
        check("rst_locked",   {31'd0, a_locked},   32'd0);
        check("rst_busy",     {31'd0, a_busy},     32'd0);
        do_reset();

        // Single line from requester 1
        req_valid = 2'b10; req_data[15:8] = "A";
        #1 check("t1_idle_ready", {30'd0, a_req_ready}, 32'd0);
        tick();
        check("t1_grant", {31'd0, a_grant}, 32'd1);
        check("t1_locked", {31'd0, a_locked}, 32'd1);
        check("t1_ready", {30'd0, a_req_ready}, 32'b10);
        tick();
        check("t1_byte_A", {24'd0, a_tx_data}, 32'h41);
        req_data[15:8] = "B";
        tick();
        check("t1_byte_B", {24'd0, a_tx_data}, 32'h42);
        check("t1_locked_B", {31'd0, a_locked}, 32'd1);
        req_data[15:8] = 8'h0A;
        tick();
        check("t1_byte_nl", {24'd0, a_tx_data}, 32'h0A);
        check("t1_nl_valid", {31'd0, a_tx_valid}, 32'd1);
        check("t1_released", {31'd0, a_locked}, 32'd0);
        req_valid = 2'b00;
        tick();
        check("t1_drained_busy", {31'd0, a_busy}, 32'd0);

        // Two competing lines must arrive whole, requester 0 first
        do_reset();
        src0 = '{8'h68, 8'h69, 8'h0A};
        src1 = '{8'h6F, 8'h6B, 8'h0A};
        cap.delete();
        run_traffic(1'b0, 100);
        exp0 = '{8'h68, 8'h69, 8'h0A, 8'h6F, 8'h6B, 8'h0A};
        check("t2_len", cap.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            e = (i < cap.size()) ? {24'd0, cap[i]} : 32'h100;
            check($sformatf("t2_byte%0d", i), e, {24'd0, exp0[i]});
        end
        exp0.delete();

        // Randomized lines: r0 lowercase, r1 uppercase, each line ends in LF
        do_reset();
        cap.delete(); src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        total = 0;
        for (int rq = 0; rq < 2; rq++) begin
            nl = $urandom_range(6, 3);
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(5, 1);
                for (int c = 0; c < len; c++) begin
                    b = (rq == 0) ? 8'h61 + 8'($urandom_range(25)) : 8'h41 + 8'($urandom_range(25));
                    if (rq == 0) begin src0.push_back(b); exp0.push_back(b); end
                    else         begin src1.push_back(b); exp1.push_back(b); end
                    total++;
                end
                if (rq == 0) begin src0.push_back(8'h0A); exp0.push_back(8'h0A); end
                else         begin src1.push_back(8'h0A); exp1.push_back(8'h0A); end
                total++;
            end
        end
        run_traffic(1'b1, 5000);
        cur = -1;
        for (int i = 0; i < cap.size(); i++) begin
            b = cap[i];
            r = (cur >= 0) ? cur : ((b >= 8'h61) ? 0 : 1);
            if (r == 0) e = (exp0.size() > 0) ? {24'd0, exp0.pop_front()} : 32'h100;
            else        e = (exp1.size() > 0) ? {24'd0, exp1.pop_front()} : 32'h100;
            check($sformatf("rnd_r%0d_byte%0d", r, i), {24'd0, b}, e);
            cur = (b == 8'h0A) ? -1 : r;
        end
        check("rnd_left0", exp0.size(), 32'd0);
        check("rnd_left1", exp1.size(), 32'd0);
        check("rnd_count", cap.size(), total);

        // No line lock: grants alternate with one idle cycle in between
        do_reset();
        req_valid = 2'b11; req_data = {8'h22, 8'h11}; tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t3_locked%0d", i), {31'd0, b_locked}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0)
                check($sformatf("t3_grant%0d", i), {31'd0, b_grant}, ((i / 2) % 2 == 0) ? 32'd0 : 32'd1);
            else
                check($sformatf("t3_data%0d", i), {24'd0, b_tx_data}, ((i / 2) % 2 == 0) ? 32'h11 : 32'h22);
        end

        // Long UART back-pressure with owner valid held must not time out
        do_reset();
        tx_ready = 1'b0; req_valid = 2'b01; req_data[7:0] = "z";
        tick();
        tick();
        req_data[7:0] = "y";
        #1 check("t4_blocked", {30'd0, a_req_ready}, 32'd0);
        for (int i = 0; i < 1000; i++) tick();
        check("t4_a_locked", {31'd0, a_locked}, 32'd1);
        check("t4_c_locked", {31'd0, c_locked}, 32'd1);
        check("t4_held_data", {24'd0, a_tx_data}, 32'h7A);
        check("t4_held_valid", {31'd0, a_tx_valid}, 32'd1);
        tx_ready = 1'b1;
        #1 check("t4_ready_rise", {30'd0, a_req_ready}, 32'b01);
        tick();
        check("t4_next_byte", {24'd0, a_tx_data}, 32'h79);
        check("t4_grant_kept", {31'd0, a_locked}, 32'd1);
        check("t4_grant_id", {31'd0, a_grant}, 32'd0);

        // Timeout of 8 idle cycles on instance C
        do_reset();
        req_valid = 2'b11; req_data = {8'h51, 8'h78}; tx_ready = 1'b1;
        tick();
        check("t5_grant0", {31'd0, c_grant}, 32'd0);
        tick();
        check("t5_byte_x", {24'd0, c_tx_data}, 32'h78);
        req_valid = 2'b10;
        for (int ed = 3; ed <= 9; ed++) begin
            tick();
            check($sformatf("t5_held_e%0d", ed), {31'd0, c_locked}, 32'd1);
        end
        tick();
        check("t5_release", {31'd0, c_locked}, 32'd0);
        check("t5_idle_grant_hold", {31'd0, c_grant}, 32'd0);
        check("t5_a_still_locked", {31'd0, a_locked}, 32'd1);
        tick();
        check("t5_new_grant", {31'd0, c_grant}, 32'd1);
        check("t5_new_locked", {31'd0, c_locked}, 32'd1);

        // Asynchronous reset mid-line with a byte held for the UART
        tx_ready = 1'b0; req_valid = 2'b01; req_data[7:0] = "m";
        tick();
        check("t6_pre_valid", {31'd0, a_tx_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_tx_valid", {31'd0, a_tx_valid}, 32'd0);
        check("t6_tx_data", {24'd0, a_tx_data}, 32'd0);
        check("t6_locked", {31'd0, a_locked}, 32'd0);
        check("t6_busy", {31'd0, a_busy}, 32'd0);
        check("t6_ready", {30'd0, a_req_ready}, 32'd0);
        tick();
        rstn = 1'b1; req_valid = 2'b11; tx_ready = 1'b1;
        tick();
        check("t6_fresh_grant", {31'd0, a_grant}, 32'd0);
        check("t6_fresh_locked", {31'd0, a_locked}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
